// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the read-side packer of the async FIFO.
package async_fifo_pkg;

    localparam int unsigned KEEP_MAX = 64;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } packer_state_t;

    // Lane-keep mask with the low cnt bits set; cnt >= KEEP_MAX gives all ones.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned cnt);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < cnt) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops WIDTH-bit items from the async FIFO read port and packs RATIO of them
// into one wide word on a valid/ready master; a flush closes a partial word.
module fifo_rd_packer
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                   rd_clk,
    input  logic                   rd_reset_n,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_data,
    output logic                   fifo_rd_en,
    input  logic                   flush,
    output logic [WIDTH*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready
);

    localparam int unsigned IDX_W  = $clog2(RATIO);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WORD_W = WIDTH * RATIO;

    packer_state_t     state;
    logic [WORD_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              inflight;

    logic              out_free;
    logic              xfer;
    logic [CNT_W-1:0]  cnt_eff;
    logic [IDX_W-1:0]  lane;

    assign lane = cnt[IDX_W-1:0];

    // Transfer decision and pop request; a transfer frees the whole accumulator this cycle.
    always_comb begin
        out_free = !m_valid || m_ready;
        xfer     = 1'b0;
        if (out_free) begin
            if ((state == FILL) && (cnt == CNT_W'(RATIO))) xfer = 1'b1;
            if ((state == FLUSH_EMIT) && (cnt != '0))     xfer = 1'b1;
        end
        cnt_eff    = xfer ? '0 : cnt;
        fifo_rd_en = rd_reset_n && !fifo_empty && (state == FILL)
                     && ((32'(cnt_eff) + 32'(inflight)) < RATIO);
    end

    // Accumulator, output register and flush sequencing.
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            state    <= FILL;
            acc      <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
            m_data   <= '0;
            m_keep   <= '0;
            m_last   <= 1'b0;
            m_valid  <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;

            if (xfer) begin
                m_data  <= acc;
                m_keep  <= RATIO'(keep_mask(32'(cnt)));
                m_last  <= (state == FLUSH_EMIT);
                m_valid <= 1'b1;
                acc     <= '0;
                cnt     <= '0;
            end else begin
                if (m_ready) m_valid <= 1'b0;
                // An item popped last cycle is on fifo_data now; it lands in the next free lane.
                if (inflight) begin
                    acc[32'(lane)*WIDTH +: WIDTH] <= fifo_data;
                    cnt <= cnt + CNT_W'(1);
                end
            end

            unique case (state)
                FILL:       if (flush) state <= FLUSH_WAIT;
                // No pops here, so any item still in flight is captured during this cycle.
                FLUSH_WAIT: state <= FLUSH_EMIT;
                FLUSH_EMIT: if ((cnt == '0) || xfer) state <= FILL;
                default:    state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: bench-owned FIFO, queue-based reference model, order scoreboard.
module tb_fifo_rd_packer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned RATIO  = 4;
    localparam int unsigned WORD_W = WIDTH * RATIO;

    typedef logic [WIDTH-1:0] item_t;

    logic              rd_clk = 1'b0;
    logic              rd_reset_n;
    logic              fifo_empty;
    item_t             fifo_data;
    logic              fifo_rd_en;
    logic              flush;
    logic [WORD_W-1:0] m_data;
    logic [RATIO-1:0]  m_keep;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .rd_clk     (rd_clk),
        .rd_reset_n (rd_reset_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    always #5 rd_clk = ~rd_clk;

    // Environment and model state
    item_t             fifo_q[$];
    item_t             popped_q[$];
    bit                empty_gate;
    item_t             mq[$];
    bit                mi;
    item_t             mi_data;
    int                mode;          // 0 fill, 1 flush wait, 2 flush emit
    bit                o_valid;
    logic [WORD_W-1:0] o_data;
    logic [RATIO-1:0]  o_keep;
    bit                o_last;

    logic [WORD_W-1:0] word_data[$];
    logic [RATIO-1:0]  word_keep[$];
    bit                word_last[$];
    int                word_cyc[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic upd_empty();
        fifo_empty = (fifo_q.size() == 0) || empty_gate;
    endtask

    task automatic model_clear();
        mq.delete();
        mi      = 1'b0;
        mi_data = '0;
        mode    = 0;
        o_valid = 1'b0;
        o_data  = '0;
        o_keep  = '0;
        o_last  = 1'b0;
    endtask

    function automatic logic [WORD_W-1:0] pack_items(input item_t q[$]);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < q.size(); i++) w[i*WIDTH +: WIDTH] = q[i];
        return w;
    endfunction

    function automatic logic [RATIO-1:0] keep_of(input int n);
        logic [RATIO-1:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    // One clock: compare at the falling edge, then advance FIFO and model after the rising edge.
    task automatic cycle();
        bit    pop, fl, rdy, xf, exp_rd;
        int    ce;
        item_t d;
        @(negedge rd_clk);
        if (!rd_reset_n) begin
            check("rst_m_valid", 64'(m_valid), 64'(0));
            check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
            @(posedge rd_clk);
            #1;
            cyc++;
            model_clear();
            return;
        end
        check("m_valid", 64'(m_valid), 64'(o_valid));
        if (o_valid) begin
            check("m_data", 64'(m_data), 64'(o_data));
            check("m_keep", 64'(m_keep), 64'(o_keep));
            check("m_last", 64'(m_last), 64'(o_last));
        end
        xf = (!o_valid || m_ready) &&
             (((mode == 0) && (mq.size() == RATIO)) || ((mode == 2) && (mq.size() != 0)));
        ce = xf ? 0 : mq.size();
        exp_rd = !fifo_empty && (mode == 0) && ((ce + int'(mi)) < int'(RATIO));
        check("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
        pop = fifo_rd_en && !fifo_empty;
        if (m_valid && m_ready) begin
            word_data.push_back(m_data);
            word_keep.push_back(m_keep);
            word_last.push_back(m_last);
            word_cyc.push_back(cyc);
            for (int i = 0; i < int'(RATIO); i++) begin
                if (m_keep[i]) begin
                    if (popped_q.size() == 0) begin
                        check("order_extra_lane", 64'(m_data[i*WIDTH +: WIDTH]), 64'hFFFF);
                    end else begin
                        check("order", 64'(m_data[i*WIDTH +: WIDTH]), 64'(popped_q.pop_front()));
                    end
                end
            end
        end
        fl  = flush;
        rdy = m_ready;
        @(posedge rd_clk);
        #1;
        cyc++;
        d = fifo_data;
        if (pop) begin
            d = fifo_q.pop_front();
            fifo_data = d;
            popped_q.push_back(d);
        end
        if (xf) begin
            o_data  = pack_items(mq);
            o_keep  = keep_of(mq.size());
            o_last  = (mode == 2);
            o_valid = 1'b1;
        end else if (rdy) begin
            o_valid = 1'b0;
        end
        case (mode)
            0:       if (fl) mode = 1;
            1:       mode = 2;
            default: if ((mq.size() == 0) || xf) mode = 0;
        endcase
        if (xf) mq.delete();
        if (mi) mq.push_back(mi_data);
        mi      = pop;
        mi_data = d;
        upd_empty();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rd_reset_n = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b1;
        empty_gate = 1'b0;
        fifo_data  = '0;
        model_clear();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(item_t'(i));
        upd_empty();

        // Reset state, with items waiting in the FIFO
        repeat (3) @(posedge rd_clk);
        #1;
        check("reset_m_valid", 64'(m_valid), 64'(0));
        check("reset_m_data", 64'(m_data), 64'(0));
        check("reset_m_keep", 64'(m_keep), 64'(0));
        check("reset_m_last", 64'(m_last), 64'(0));
        check("reset_rd_en", 64'(fifo_rd_en), 64'(0));
        #2 rd_reset_n = 1'b1;

        // Two full words back to back
        base = word_data.size();
        repeat (16) cycle();
        check("t1_words", 64'(word_data.size() - base), 64'(2));
        if (word_data.size() >= base + 2) begin
            check("t1_word0", 64'(word_data[base]), 64'h04030201);
            check("t1_word1", 64'(word_data[base+1]), 64'h08070605);
            check("t1_keep0", 64'(word_keep[base]), 64'hF);
            check("t1_last1", 64'(word_last[base+1]), 64'(0));
            check("t1_gap", 64'(word_cyc[base+1] - word_cyc[base]), 64'(5));
        end

        // Partial word via flush; no pops while flushing
        base = word_data.size();
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        upd_empty();
        repeat (6) cycle();
        check("t2_model_lanes", 64'(mq.size()), 64'(3));
        do_flush();
        fifo_q.push_back(8'h44);
        upd_empty();
        #1 check("t2_rd_en_wait", 64'(fifo_rd_en), 64'(0));
        cycle();
        #1 check("t2_rd_en_emit", 64'(fifo_rd_en), 64'(0));
        cycle();
        #1 check("t2_rd_en_fill", 64'(fifo_rd_en), 64'(1));
        repeat (4) cycle();
        check("t2_words", 64'(word_data.size() - base), 64'(1));
        if (word_data.size() >= base + 1) begin
            check("t2_data", 64'(word_data[base]), 64'h00332211);
            check("t2_keep", 64'(word_keep[base]), 64'b0111);
            check("t2_last", 64'(word_last[base]), 64'(1));
        end
        do_flush();
        repeat (5) cycle();
        check("t2b_words", 64'(word_data.size() - base), 64'(2));
        if (word_data.size() >= base + 2) begin
            check("t2b_data", 64'(word_data[base+1]), 64'h00000044);
            check("t2b_keep", 64'(word_keep[base+1]), 64'b0001);
        end

        // Flush of an empty accumulator emits nothing and returns to packing
        base = word_data.size();
        do_flush();
        cycle();
        cycle();
        fifo_q.push_back(8'h55);
        upd_empty();
        #1 check("t3_back_in_fill", 64'(fifo_rd_en), 64'(1));
        repeat (4) cycle();
        check("t3_no_word", 64'(word_data.size() - base), 64'(0));
        do_flush();
        repeat (5) cycle();
        check("t3_tail_words", 64'(word_data.size() - base), 64'(1));

        // Backpressure with 12 items queued
        base = word_data.size();
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) fifo_q.push_back(item_t'(8'hA0 + i));
        upd_empty();
        repeat (20) cycle();
        check("t4_held_valid", 64'(m_valid), 64'(1));
        check("t4_held_data", 64'(m_data), 64'hA3A2A1A0);
        check("t4_rd_en_stopped", 64'(fifo_rd_en), 64'(0));
        check("t4_no_accept", 64'(word_data.size() - base), 64'(0));
        m_ready = 1'b1;
        repeat (15) cycle();
        check("t4_words", 64'(word_data.size() - base), 64'(3));
        if (word_data.size() >= base + 3) begin
            check("t4_w0", 64'(word_data[base]), 64'hA3A2A1A0);
            check("t4_w1", 64'(word_data[base+1]), 64'hA7A6A5A4);
            check("t4_w2", 64'(word_data[base+2]), 64'hABAAA9A8);
        end

        // Asynchronous reset after two lanes are captured
        for (int i = 0; i < 6; i++) fifo_q.push_back(item_t'(8'hC0 + i));
        upd_empty();
        for (int g = 0; g < 20 && mq.size() != 2; g++) cycle();
        check("t5_two_lanes", 64'(mq.size()), 64'(2));
        #2 rd_reset_n = 1'b0;
        #1;
        check("t5_valid_now", 64'(m_valid), 64'(0));
        check("t5_rd_en_now", 64'(fifo_rd_en), 64'(0));
        model_clear();
        popped_q.delete();
        repeat (2) cycle();
        #2 rd_reset_n = 1'b1;
        fifo_q.push_back(8'hC6);
        upd_empty();
        base = word_data.size();
        repeat (12) cycle();
        check("t5_words", 64'(word_data.size() - base), 64'(1));
        if (word_data.size() >= base + 1) begin
            check("t5_fresh", 64'(word_data[base]), 64'hC6C5C4C3);
        end

        // fifo_empty toggling every cycle
        for (int i = 0; i < 40; i++) fifo_q.push_back(item_t'($urandom));
        for (int i = 0; i < 120; i++) begin
            empty_gate = ~empty_gate;
            upd_empty();
            cycle();
        end

        // Random traffic, backpressure and flushes
        for (int i = 0; i < 2500; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 5)); k++) fifo_q.push_back(item_t'($urandom));
            end
            empty_gate = ($urandom_range(0, 3) == 0);
            m_ready    = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 25) == 0);
            upd_empty();
            cycle();
        end

        // Drain everything out
        flush      = 1'b0;
        empty_gate = 1'b0;
        m_ready    = 1'b1;
        upd_empty();
        for (int g = 0; g < 300 && fifo_q.size() != 0; g++) cycle();
        repeat (8) cycle();
        do_flush();
        repeat (8) cycle();
        check("drain_fifo", 64'(fifo_q.size()), 64'(0));
        check("drain_all_emitted", 64'(popped_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain. It pops WIDTH-bit items from the FIFO and packs RATIO consecutive items into one wide word on a valid/ready master interface. A flush request emits a partial word with a lane-keep mask.

## Interface
- WIDTH, 8, item width in bits; equals the FIFO data width
- RATIO, 4, items per output word; power of two, ≥2
- rd_clk  in  1  read-domain clock; the only clock
- rd_reset_n  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  WIDTH  FIFO read data; holds the popped item the cycle after a pop
- fifo_rd_en  out  1  pop request; combinational
- flush  in  1  single-cycle request to emit the current partial word
- m_data  out  WIDTH*RATIO  packed word; lane i is bits [i*WIDTH +: WIDTH]
- m_keep  out  RATIO  bit i set means lane i holds valid data
- m_last  out  1  word was closed by a flush
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts the word

## Operation
- Internal state:
  - acc: RATIO lanes
  - cnt: lanes filled, 0..RATIO, width clog2(RATIO)+1
  - inflight: 1 bit, pop issued last cycle
  - output register
  - FSM
- Pop rule: fifo_rd_en = !fifo_empty && state==FILL && (cnt_eff + inflight < RATIO).
  - cnt_eff is 0 when acc transfers to the output register this cycle; otherwise cnt_eff = cnt.
  - A pop with fifo_empty low removes exactly one item.
- Capture: when inflight=1, fifo_data is written to lane cnt and cnt increments. Lane 0 is the first item popped (little-endian).
- Transfer: happens when the output register is free (!m_valid || m_ready). On transfer:
  - acc loads into m_data, m_keep and m_last.
  - m_valid is set.
  - cnt goes to 0 and acc clears.
- A full word transfers when cnt==RATIO, with m_keep all ones and m_last=0.
- FSM states, type packer_state_t:
  - FILL: normal packing. flush=1 moves the FSM to FLUSH_WAIT. A flush while not in FILL is ignored.
  - FLUSH_WAIT: no new pops. Once inflight=0 and the item in flight is captured, move to FLUSH_EMIT.
  - FLUSH_EMIT: if cnt==0, emit nothing and return to FILL. Otherwise, on transfer emit the partial word and return to FILL:
    - m_keep = (1<<cnt)-1
    - unused lanes zero
    - m_last=1
- Flush when cnt==RATIO: the full word is emitted with m_last=1.
- The output register holds m_data, m_keep and m_last stable while m_valid && !m_ready.

## Timing
- Reset: all of the following are cleared:
  - m_valid, m_last, m_data, m_keep, cnt and inflight go to 0
  - FSM goes to FILL
  - fifo_rd_en = 0 while rd_reset_n is low
- Reset mid-word discards partial data; no word is emitted.
- Pop-to-capture latency: 1 cycle.
- Last-lane-capture-to-m_valid latency: 1 cycle.
- Sustained throughput with FIFO non-empty and m_ready=1: RATIO items per RATIO+1 cycles.
- Backpressure:
  - While m_valid && !m_ready with acc full, pops stop.
  - No item is ever dropped or duplicated.
- If fifo_empty rises while a pop is in flight, the in-flight item is still captured.
- Flush latency: at most 2 cycles plus any output backpressure.

## Structure
- Package async_fifo_pkg holds:
  - typedef enum packer_state_t {FILL, FLUSH_WAIT, FLUSH_EMIT}
  - function keep_mask(cnt)
- Single module; no sub-module. Lane write uses an indexed part-select.

## Test plan
- FIFO preloaded with 0x01..0x08, m_ready=1, RATIO=4 → two words:
  - 0x04030201 then 0x08070605
  - m_keep=4'hF, m_last=0
  - second m_valid 5 cycles after the first
- Preload 0x11,0x22,0x33, then flush once all three are captured → one word 0x00332211, m_keep=4'b0111, m_last=1; fifo_rd_en stays low until back in FILL.
- Flush with cnt=0 and no pop in flight → no m_valid; FSM back in FILL within 2 cycles.
- m_ready held low for 20 cycles with 12 items queued:
  - first word held stable
  - fifo_rd_en low once acc is full
  - after release, the words appear in order with no loss
- rd_reset_n asserted asynchronously after 2 lanes are captured:
  - m_valid=0 and fifo_rd_en=0 immediately
  - after release, the next 4 items form a fresh word starting at lane 0
- fifo_empty toggling every cycle → every popped item appears exactly once, in order, across the emitted words.
